// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-rate divisor helper, frame length and receiver states.
package uart_pkg;

  localparam int BIT_TOTAL = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to a configurable level.
module bit_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_stream_rx.sv
// 8N1 UART receiver with mid-bit sampling and a single ready/valid holding register.
module uart_stream_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxi,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int DATA_BITS    = BIT_TOTAL - 2;

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_stream_rx: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  bit_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxi),
    .q   (rx_s)
  );

  assign busy = (state != S_IDLE);

  // cnt holds (edges since last sample point) - 1, so sample when it reaches period-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_vld && rx_rdy)
        rx_vld <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1))
              state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            if (rx_s) begin
              // Back to IDLE at the stop midpoint so an adjacent start bit is caught.
              state <= S_IDLE;
              if (!rx_vld || rx_rdy) begin
                rx_byte <= shreg;
                rx_vld  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_rx.sv
// Self-checking bench for uart_stream_rx: behavioural line driver plus byte/event scoreboard.
module tb_uart_stream_rx;

  localparam int CLK_HZ    = 100_000_000;
  localparam int BAUD      = 5_000_000;
  localparam int CPB       = CLK_HZ / BAUD;
  localparam int HALF      = CPB / 2;
  // Edges from the start-bit drive to the stop sample: 2 sync flops + first IDLE edge, then HALF + 9 bits.
  localparam int STOP_EDGE = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxi = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_stream_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxi       (rxi),
    .rx_byte   (rx_byte),
    .rx_vld    (rx_vld),
    .rx_rdy    (rx_rdy),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a byte is consumed whenever valid and ready coincide.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_vld && rx_rdy) got_q.push_back(rx_byte);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, required finish", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxi = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rxi = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if ({rx_vld, busy, frame_err, overrun, rx_byte} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs: got vld=%b busy=%b fe=%b ov=%b byte=%02h, required all 0",
                 rx_vld, busy, frame_err, overrun, rx_byte);
      end
    end
    rxi = 1'b1;
    align();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rx_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b vld=%b, required 0 0", busy, rx_vld);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    clear_sb();
    rx_rdy = 1'b1;
    align();
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3 * CPB)) @(posedge clk);
      #1;
      send_frame(b, 1'b1);
      exp_q.push_back(b);
    end
    repeat (2 * CPB) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL loopback_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL loopback_byte[%0d]: got %02h, required %02h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL loopback_errors: got fe=%0d ov=%0d, required 0 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    bit saw_busy = 0;
    bit dropped = 0;
    clear_sb();
    align();
    rxi = 1'b0;
    for (int k = 0; k < 30 && !dropped; k++) begin
      @(negedge clk);
      if (k == 9) rxi = 1'b1;
      if (busy) saw_busy = 1;
      else if (saw_busy) dropped = 1;
    end
    rxi = 1'b1;
    n_checks++;
    if (!saw_busy || !dropped) begin
      n_fail++;
      $display("FAIL glitch_busy: got saw_busy=%0d dropped=%0d within 30 clks, required 1 1", saw_busy, dropped);
    end
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 0 || rx_vld !== 1'b0 || fe_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_quiet: got bytes=%0d vld=%b fe=%0d busy=%b, required 0 0 0 0",
               got_q.size(), rx_vld, fe_cnt, busy);
    end
  endtask

  task automatic test_framing();
    logic [7:0] b;
    clear_sb();
    rx_rdy = 1'b1;
    b = 8'h3C;
    align();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    n_checks++;
    if (fe_cnt !== 1 || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL framing_err: got fe=%0d bytes=%0d, required 1 0", fe_cnt, got_q.size());
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL framing_break_busy: got busy=%b while line low, required 1", busy);
    end
    rxi = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rx_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_recover: got busy=%b vld=%b, required 0 0", busy, rx_vld);
    end
  endtask

  task automatic test_overrun();
    logic ov_before, ov_at;
    // Held byte blocks the second one.
    clear_sb();
    rx_rdy = 1'b0;
    align();
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 ov_before = overrun;
        @(posedge clk);
        #1 ov_at = overrun;
      end
    join
    n_checks++;
    if (ov_before !== 1'b0 || ov_at !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_timing: got before=%b at=%b, required 0 1", ov_before, ov_at);
    end
    n_checks++;
    if (ov_cnt !== 1 || rx_vld !== 1'b1 || rx_byte !== 8'h11 || fe_cnt !== 0) begin
      n_fail++;
      $display("FAIL overrun_hold: got ov=%0d vld=%b byte=%02h fe=%0d, required 1 1 11 0",
               ov_cnt, rx_vld, rx_byte, fe_cnt);
    end
    rx_rdy = 1'b1;
    align();
    rx_rdy = 1'b0;
    n_checks++;
    if (rx_vld !== 1'b0 || got_q.size() !== 1 || got_q[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL overrun_drain: got vld=%b bytes=%0d, required 0 1 (11)", rx_vld, got_q.size());
    end

    // Ready on the exact delivery edge frees the register for the new byte.
    clear_sb();
    align();
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 rx_rdy = 1'b1;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
      end
    join
    n_checks++;
    if (ov_cnt !== 0 || rx_vld !== 1'b1 || rx_byte !== 8'h22) begin
      n_fail++;
      $display("FAIL simult_load: got ov=%0d vld=%b byte=%02h, required 0 1 22", ov_cnt, rx_vld, rx_byte);
    end
    rx_rdy = 1'b1;
    align();
    rx_rdy = 1'b0;
    n_checks++;
    if (got_q.size() !== 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22 || rx_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL simult_order: got bytes=%0d vld=%b, required 2 (11,22) 0", got_q.size(), rx_vld);
    end
  endtask

  task automatic test_reset_midframe();
    clear_sb();
    rx_rdy = 1'b1;
    align();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxi = 1'b1;
    repeat (HALF - 3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_vld, busy, frame_err, overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midframe_reset: got vld=%b busy=%b fe=%b ov=%b, required 0 0 0 0",
               rx_vld, busy, frame_err, overrun);
    end
    align();
    rst = 1'b0;
    repeat (5 * CPB) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || got_q.size() !== 0 || fe_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL midframe_abort: got busy=%b bytes=%0d fe=%0d ov=%0d, required 0 0 0 0",
               busy, got_q.size(), fe_cnt, ov_cnt);
    end
    send_frame(8'h5A, 1'b1);
    repeat (CPB) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL midframe_resume: got bytes=%0d first=%02h, required 1 5a",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    rx_rdy = 1'b1;
    align();
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b1);
      exp_q.push_back(8'(i));
    end
    repeat (2 * CPB) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== 256 || fe_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got bytes=%0d fe=%0d ov=%0d, required 256 0 0", got_q.size(), fe_cnt, ov_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_byte[%0d]: got %02h, required %02h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
